// File: rtl/arbitro_wrr.sv
`default_nettype none
// ============================================================================
// arbitro_wrr : egress arbiter (RR / WRR / strict priority) feeding one FIFO
// Revision    : 1.0
// ============================================================================
module arbitro_wrr #(
   parameter  int QUEUE_QUANTITY    = 4,
   parameter  int DATA_BITS         = 8,
   parameter  int MAX_WEIGHT        = 64,
   parameter  int TIPOS_ROUND_ROBIN = 3,
   localparam int QW                = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1,
   localparam int WW                = $clog2(MAX_WEIGHT + 1),
   localparam int MW                = $clog2(TIPOS_ROUND_ROBIN)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enb,
   input  logic [MW-1:0]                       mode,
   input  logic [QUEUE_QUANTITY*WW-1:0]        weights,
   input  logic [QUEUE_QUANTITY-1:0]           fifo_empty,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
   output logic [QUEUE_QUANTITY-1:0]           fifo_pop,
   input  logic                                out_almost_full,
   output logic                                out_push,
   output logic [DATA_BITS-1:0]                out_data,
   output logic [QW-1:0]                       grant,
   output logic [WW-1:0]                       credit
);

   localparam logic [MW-1:0] MODE_RR   = MW'(0);
   localparam logic [MW-1:0] MODE_WRR  = MW'(1);
   localparam logic [MW-1:0] MODE_PRIO = MW'(2);
   localparam logic [WW-1:0] W_MAX     = WW'(MAX_WEIGHT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE  = 2'd1,
      SWITCH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [QW-1:0]       grant_q, grant_d;
   logic [WW-1:0]       credit_q, credit_d;
   logic [MW-1:0]       mode_q, mode_d;
   logic [WW-1:0]       weight_q, weight_d;
   logic                push_q, push_d;
   logic [QW-1:0]       sel_q, sel_d;

   logic [MW-1:0]             mode_eff;
   logic [WW-1:0]             w_clamp [QUEUE_QUANTITY];
   logic [QUEUE_QUANTITY-1:0] eligible;
   logic                      pick_found;
   logic [QW-1:0]             pick_idx;
   logic                      lower_busy;
   logic                      active;
   logic                      can_pop;
   int                        start_int;
   int                        scan_int;
   logic [QW-1:0]             scan_idx;

   assign mode_eff = (int'(mode) >= TIPOS_ROUND_ROBIN) ? MODE_RR : mode;

   // Eligibility uses the live mode: it only matters in IDLE/SWITCH, where mode is sampled.
   for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_weight
      assign w_clamp[i]  = (weights[i*WW +: WW] > W_MAX) ? W_MAX : weights[i*WW +: WW];
      assign eligible[i] = ~fifo_empty[i] & ((mode_eff != MODE_WRR) | (w_clamp[i] != '0));
   end

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      lower_busy = 1'b0;
      scan_int   = 0;
      scan_idx   = '0;
      // IDLE resumes at the current grant; SWITCH starts one past it and may wrap to itself.
      start_int  = (state_q == SWITCH) ? int'(grant_q) + 1 : int'(grant_q);
      if (mode_eff == MODE_PRIO) begin
         for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               pick_found = 1'b1;
               pick_idx   = QW'(i);
            end
         end
      end else begin
         for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
            scan_int = (start_int + k) % QUEUE_QUANTITY;
            scan_idx = QW'(scan_int);
            if (eligible[scan_idx]) begin
               pick_found = 1'b1;
               pick_idx   = scan_idx;
            end
         end
      end
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
         if ((i < int'(grant_q)) && !fifo_empty[i]) begin
            lower_busy = 1'b1;
         end
      end
   end

   assign active  = enb & ~out_almost_full;
   assign can_pop = ~rst & (state_q == SERVE) & active & ~fifo_empty[grant_q];

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      mode_d   = mode_q;
      weight_d = weight_q;
      case (state_q)
         IDLE, SWITCH: begin
            if (state_q == SWITCH) begin
               credit_d = '0;
            end
            if (pick_found && enb) begin
               state_d  = SERVE;
               grant_d  = pick_idx;
               credit_d = '0;
               mode_d   = mode_eff;
               weight_d = w_clamp[pick_idx];
            end else begin
               state_d  = IDLE;
            end
         end
         SERVE: begin
            if (&fifo_empty) begin
               state_d = IDLE;
            end else if (active) begin
               if (fifo_empty[grant_q]) begin
                  state_d = SWITCH;
               end else begin
                  case (mode_q)
                     MODE_WRR: begin
                        if (credit_q != W_MAX) begin
                           credit_d = credit_q + WW'(1);
                        end
                        if (({1'b0, credit_q} + (WW+1)'(1)) >= {1'b0, weight_q}) begin
                           state_d = SWITCH;
                        end
                     end
                     MODE_PRIO: begin
                        if (lower_busy) begin
                           state_d = SWITCH;
                        end
                     end
                     default: begin
                        state_d = SWITCH;
                     end
                  endcase
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      push_d = can_pop;
      sel_d  = grant_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         credit_q <= '0;
         mode_q   <= MODE_RR;
         weight_q <= '0;
         push_q   <= 1'b0;
         sel_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         credit_q <= credit_d;
         mode_q   <= mode_d;
         weight_q <= weight_d;
         push_q   <= push_d;
         sel_q    <= sel_d;
      end
   end

   // A word popped just before reset is discarded rather than pushed during reset.
   assign fifo_pop = can_pop ? (QUEUE_QUANTITY'(1) << grant_q) : '0;
   assign out_push = push_q & ~rst;
   assign out_data = out_push ? fifo_data[int'(sel_q)*DATA_BITS +: DATA_BITS] : '0;
   assign grant    = grant_q;
   assign credit   = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_wrr.sv
`default_nettype none
// ============================================================================
// tb_arbitro_wrr : directed scoreboard bench for arbitro_wrr
// Revision       : 1.0
// ============================================================================
module tb_arbitro_wrr;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic        out_almost_full;
   logic [1:0]  mode;
   logic [27:0] weights;
   logic [3:0]  fifo_empty;
   logic [3:0]  fifo_pop;
   logic [31:0] fifo_data;
   logic        out_push;
   logic [7:0]  out_data;
   logic [1:0]  grant;
   logic [6:0]  credit;

   int checks     = 0;
   int errors     = 0;
   int push_count = 0;

   logic [7:0]  exp_q [$];
   logic [7:0]  qmem [4][32];
   int unsigned head [4] = '{default: 0};
   int unsigned tail [4] = '{default: 0};
   logic [31:0] rd_data = '0;

   logic [7:0] rr_exp  [12] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11,
                                8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};
   logic [7:0] wrr_exp [14] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51, 8'h60,
                                8'h44, 8'h45, 8'h46, 8'h47, 8'h52, 8'h53, 8'h61};
   logic [7:0] pr_exp  [8]  = '{8'h80, 8'h81, 8'h90, 8'h91, 8'h82, 8'h83, 8'h84, 8'h85};
   logic [7:0] bp_exp  [6]  = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
   logic [7:0] mr_exp  [4]  = '{8'hD0, 8'hC1, 8'hD1, 8'hC2};

   always #5 clk = ~clk;

   arbitro_wrr dut (
      .clk             (clk),
      .rst             (rst),
      .enb             (enb),
      .mode            (mode),
      .weights         (weights),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .fifo_pop        (fifo_pop),
      .out_almost_full (out_almost_full),
      .out_push        (out_push),
      .out_data        (out_data),
      .grant           (grant),
      .credit          (credit)
   );

   // Input queue model: read data appears the cycle after the pop.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (fifo_pop[i]) begin
            rd_data[i*8 +: 8] <= qmem[i][head[i][4:0]];
            head[i]           <= head[i] + 1;
         end
      end
   end

   always_comb begin
      fifo_empty = '0;
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i] = (head[i] == tail[i]);
      end
   end

   assign fifo_data = rd_data;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic load(input int q, input logic [7:0] d);
      qmem[q][tail[q][4:0]] = d;
      tail[q] = tail[q] + 1;
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         check("pop_onehot_nonempty",
               32'(($countones(fifo_pop) <= 1) && ((fifo_pop & fifo_empty) == 4'b0000)), 32'd1);
         if (out_push) begin
            push_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_push: actual=%0h expected=none", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e));
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: actual=%0d words outstanding required=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int bp_bad;
      rst             = 1'b1;
      enb             = 1'b1;
      out_almost_full = 1'b0;
      mode            = 2'd0;
      weights         = '0;
      for (int q = 0; q < 4; q++) begin
         for (int n = 0; n < 3; n++) begin
            load(q, 8'(q*16 + n));
         end
      end
      fork
         monitor();
      join_none

      // Reset with all queues non-empty
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_fifo_pop", 32'(fifo_pop), 0);
      check("reset_out_push", 32'(out_push), 0);
      check("reset_out_data", 32'(out_data), 0);
      check("reset_grant", 32'(grant), 0);
      check("reset_credit", 32'(credit), 0);
      tick();
      foreach (rr_exp[i]) exp_q.push_back(rr_exp[i]);
      rst = 1'b0;
      drain("rr");

      // Weighted round robin, weights 4,2,1,0
      mode    = 2'd1;
      weights = {7'd0, 7'd1, 7'd2, 7'd4};
      for (int n = 0; n < 8; n++) load(0, 8'h40 + 8'(n));
      for (int n = 0; n < 4; n++) load(1, 8'h50 + 8'(n));
      for (int n = 0; n < 2; n++) load(2, 8'h60 + 8'(n));
      for (int n = 0; n < 3; n++) load(3, 8'h70 + 8'(n));
      foreach (wrr_exp[i]) exp_q.push_back(wrr_exp[i]);
      repeat (4) tick();
      @(negedge clk);
      check("wrr_credit_q0_last", 32'(credit), 3);
      check("wrr_grant_q0", 32'(grant), 0);
      repeat (2) tick();
      @(negedge clk);
      check("wrr_grant_q1", 32'(grant), 1);
      check("wrr_credit_cleared", 32'(credit), 0);
      drain("wrr");
      check("wrr_q3_untouched", tail[3] - head[3], 3);
      repeat (3) tick();
      check("wrr_q3_still_untouched", tail[3] - head[3], 3);
      tail[3] = head[3];
      tick();

      // Strict priority: q0 preempts q2
      mode = 2'd2;
      for (int n = 0; n < 6; n++) load(2, 8'h80 + 8'(n));
      foreach (pr_exp[i]) exp_q.push_back(pr_exp[i]);
      repeat (2) tick();
      load(0, 8'h90);
      load(0, 8'h91);
      repeat (2) tick();
      @(negedge clk);
      check("prio_grant_q0", 32'(grant), 0);
      drain("prio");

      // Backpressure mid-burst
      for (int n = 0; n < 6; n++) load(1, 8'hB0 + 8'(n));
      foreach (bp_exp[i]) exp_q.push_back(bp_exp[i]);
      repeat (3) tick();
      out_almost_full = 1'b1;
      base   = push_count;
      bp_bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) check("bp_pop_same_cycle", 32'(fifo_pop), 0);
         if (fifo_pop != 4'b0000 || grant != 2'd1) bp_bad++;
         tick();
      end
      check("bp_one_more_push", push_count - base, 1);
      check("bp_hold", bp_bad, 0);
      out_almost_full = 1'b0;
      drain("bp");

      // Reset the cycle after a pop
      mode = 2'd0;
      for (int n = 0; n < 3; n++) load(2, 8'hC0 + 8'(n));
      tick();
      @(negedge clk);
      check("mr_pop_issued", 32'(fifo_pop), 32'h4);
      tick();
      rst = 1'b1;
      load(0, 8'hD0);
      load(0, 8'hD1);
      foreach (mr_exp[i]) exp_q.push_back(mr_exp[i]);
      @(negedge clk);
      check("mr_no_push", 32'(out_push), 0);
      check("mr_no_pop", 32'(fifo_pop), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mr_grant", 32'(grant), 0);
      check("mr_credit", 32'(credit), 0);
      drain("mr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
